// File: rtl/hud_if.sv
// HUD game-state bus: collision/frame strobes toward the controller and the
// committed score/lives/status values back toward the HUD renderer.
interface hud_if;
  // Every strobe is a single-cycle pulse with no valid/ready handshake.
  // The controller samples each strobe on exactly one rising clk edge and cannot
  // stall the sender. Returned values are registered and stay stable between
  // commits.
  logic        frame_start;
  logic        game_start;
  logic        alien_hit;
  logic [7:0]  alien_pts;
  logic        ufo_hit;
  logic [7:0]  ufo_pts;
  logic        player_hit;
  logic [13:0] score;
  logic [1:0]  lives;
  logic        game_over;
  logic        lives_blink;
  logic        invuln;

  modport master (
    output frame_start, game_start, alien_hit, alien_pts, ufo_hit, ufo_pts, player_hit,
    input  score, lives, game_over, lives_blink, invuln
  );

  modport slave (
    input  frame_start, game_start, alien_hit, alien_pts, ufo_hit, ufo_pts, player_hit,
    output score, lives, game_over, lives_blink, invuln
  );
endinterface

// File: rtl/hud_ctrl.sv
// Frame-synchronous score/lives controller for the HUD. Hits accumulate during the
// frame and commit on frame_start. Define HUD_EXTRA_LIFE_EN for the 1000-point bonus life.
module hud_ctrl #(
  parameter int START_LIVES   = 3,
  parameter int SCORE_MAX     = 9999,
  parameter int INVULN_FRAMES = 60,
  parameter int BLINK_FRAMES  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  hud_if.slave       bus,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PLAY      = 2'd1,
    INVULN    = 2'd2,
    GAME_OVER = 2'd3
  } state_e;

  localparam logic [14:0] SCORE_MAX_W = 15'(SCORE_MAX);
  localparam logic [13:0] SCORE_CEIL  = 14'(SCORE_MAX);
  localparam logic [1:0]  LIVES_INIT  = 2'(START_LIVES);

  state_e      state_q, state_d;
  logic [13:0] score_q, score_d;
  logic [1:0]  lives_q, lives_d;
  logic [9:0]  pend_q, pend_d;
  logic        hit_pend_q, hit_pend_d;
  logic [15:0] inv_cnt_q, inv_cnt_d;
  logic [15:0] blink_cnt_q, blink_cnt_d;
  logic        blink_q, blink_d;
`ifdef HUD_EXTRA_LIFE_EN
  logic        bonus_done_q, bonus_done_d;
`endif

  // Datapath terms shared by the accumulate and commit paths.
  logic [9:0]  ev_pts;
  logic [10:0] pend_sum;
  logic [9:0]  pend_acc;
  logic [14:0] score_sum;
  logic [13:0] score_cmt;
  logic [1:0]  lives_dec;
  logic        active;

  always_comb begin
    ev_pts    = (bus.alien_hit ? {2'b00, bus.alien_pts} : 10'd0)
              + (bus.ufo_hit   ? {2'b00, bus.ufo_pts}   : 10'd0);
    pend_sum  = {1'b0, pend_q} + {1'b0, ev_pts};
    pend_acc  = pend_sum[10] ? 10'h3FF : pend_sum[9:0];
    score_sum = {1'b0, score_q} + {5'b00000, pend_q};
    score_cmt = (score_sum > SCORE_MAX_W) ? SCORE_CEIL : score_sum[13:0];
    lives_dec = (hit_pend_q && (lives_q != 2'd0)) ? lives_q - 2'd1 : lives_q;
    active    = (state_q == PLAY) || (state_q == INVULN);
  end

  always_comb begin
    state_d      = state_q;
    score_d      = score_q;
    lives_d      = lives_q;
    pend_d       = pend_q;
    hit_pend_d   = hit_pend_q;
    inv_cnt_d    = inv_cnt_q;
    blink_cnt_d  = blink_cnt_q;
    blink_d      = blink_q;
`ifdef HUD_EXTRA_LIFE_EN
    bonus_done_d = bonus_done_q;
`endif

    if (!active) begin
      if (bus.game_start) begin
        state_d      = PLAY;
        score_d      = 14'd0;
        lives_d      = LIVES_INIT;
        pend_d       = 10'd0;
        hit_pend_d   = 1'b0;
        inv_cnt_d    = 16'd0;
        blink_cnt_d  = 16'd0;
`ifdef HUD_EXTRA_LIFE_EN
        bonus_done_d = 1'b0;
`endif
      end
    end else if (bus.frame_start) begin
      // Commit: same-cycle hits seed the next frame rather than this one.
      score_d    = score_cmt;
      pend_d     = ev_pts;
      lives_d    = lives_dec;
      hit_pend_d = (state_q == PLAY) && bus.player_hit;

      if (hit_pend_q) begin
        if (lives_dec == 2'd0) begin
          state_d    = GAME_OVER;
          hit_pend_d = 1'b0;
        end else begin
          state_d     = INVULN;
          inv_cnt_d   = 16'd0;
          blink_cnt_d = 16'd0;
        end
      end else if (state_q == INVULN) begin
        if ((int'(inv_cnt_q) + 1) >= (INVULN_FRAMES - 1)) begin
          state_d     = PLAY;
          inv_cnt_d   = 16'd0;
          blink_cnt_d = 16'd0;
        end else begin
          inv_cnt_d = inv_cnt_q + 16'd1;
          if (int'(blink_cnt_q) >= (BLINK_FRAMES - 1)) begin
            blink_cnt_d = 16'd0;
            blink_d     = ~blink_q;
          end else begin
            blink_cnt_d = blink_cnt_q + 16'd1;
          end
        end
      end

`ifdef HUD_EXTRA_LIFE_EN
      // The flag is spent on the first crossing even when no life can be added.
      if (!bonus_done_q && (score_q < 14'd1000) && (score_cmt >= 14'd1000)) begin
        bonus_done_d = 1'b1;
        if ((lives_dec != 2'd0) && (lives_dec < 2'd3)) begin
          lives_d = lives_dec + 2'd1;
        end
      end
`endif
    end else begin
      pend_d = pend_acc;
      if ((state_q == PLAY) && bus.player_hit) begin
        hit_pend_d = 1'b1;
      end
    end

    if (state_d != INVULN) begin
      blink_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      score_q      <= 14'd0;
      lives_q      <= LIVES_INIT;
      pend_q       <= 10'd0;
      hit_pend_q   <= 1'b0;
      inv_cnt_q    <= 16'd0;
      blink_cnt_q  <= 16'd0;
      blink_q      <= 1'b0;
`ifdef HUD_EXTRA_LIFE_EN
      bonus_done_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      score_q      <= score_d;
      lives_q      <= lives_d;
      pend_q       <= pend_d;
      hit_pend_q   <= hit_pend_d;
      inv_cnt_q    <= inv_cnt_d;
      blink_cnt_q  <= blink_cnt_d;
      blink_q      <= blink_d;
`ifdef HUD_EXTRA_LIFE_EN
      bonus_done_q <= bonus_done_d;
`endif
    end
  end

  assign bus.score       = score_q;
  assign bus.lives       = lives_q;
  assign bus.game_over   = (state_q == GAME_OVER);
  assign bus.invuln      = (state_q == INVULN);
  assign bus.lives_blink = blink_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_hud_ctrl.sv
// Directed bench for hud_ctrl: expected HUD values are queued per commit strobe
// and a monitor compares them the cycle after each frame_start/game_start.
module tb_hud_ctrl;
  localparam int W = 19;

`ifdef HUD_EXTRA_LIFE_EN
  localparam logic [1:0] BONUS_LV = 2'd3;
`else
  localparam logic [1:0] BONUS_LV = 2'd2;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;

  hud_if bus();

  hud_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock/reset
  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  int           checks = 0;
  int           failures = 0;
  logic         evt_q = 1'b0;
  logic [W-1:0] mon_got;
  logic [W-1:0] mon_exp;

  function automatic logic [W-1:0] e(input logic [13:0] sc, input logic [1:0] lv,
                                     input logic go, input logic inv, input logic blk);
    return {sc, lv, go, inv, blk};
  endfunction

  // scoreboard monitor
  always @(posedge clk) evt_q <= rst_n && (bus.frame_start || bus.game_start);

  always @(negedge clk) begin
    if (evt_q) begin
      mon_got = {bus.score, bus.lives, bus.game_over, bus.invuln, bus.lives_blink};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL commit_unexpected: got score=%0d lives=%0d, no value queued",
                 mon_got[18:5], mon_got[4:3]);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          failures++;
          $display("FAIL commit @%0t: got score=%0d lives=%0d go=%0d inv=%0d blink=%0d, required score=%0d lives=%0d go=%0d inv=%0d blink=%0d",
                   $time, mon_got[18:5], mon_got[4:3], mon_got[2], mon_got[1], mon_got[0],
                   mon_exp[18:5], mon_exp[4:3], mon_exp[2], mon_exp[1], mon_exp[0]);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input bit fs, input bit gs, input bit ah, input logic [7:0] ap,
                       input bit uh, input logic [7:0] up, input bit ph);
    @(negedge clk);
    bus.frame_start = fs;
    bus.game_start  = gs;
    bus.alien_hit   = ah;
    bus.alien_pts   = ap;
    bus.ufo_hit     = uh;
    bus.ufo_pts     = up;
    bus.player_hit  = ph;
  endtask

  task automatic idle();
    drive(0, 0, 0, 8'd0, 0, 8'd0, 0);
  endtask

  task automatic commit(input bit fs, input bit gs, input bit ah, input logic [7:0] ap,
                        input bit uh, input logic [7:0] up, input bit ph,
                        input logic [W-1:0] exp);
    drive(fs, gs, ah, ap, uh, up, ph);
    exp_q.push_back(exp);
  endtask

  task automatic frame(input logic [W-1:0] exp);
    commit(1, 0, 0, 8'd0, 0, 8'd0, 0, exp);
  endtask

  task automatic gstart(input logic [W-1:0] exp);
    commit(0, 1, 0, 8'd0, 0, 8'd0, 0, exp);
  endtask

  // Frames k=first_k..59 of an invulnerability window; optional 13-point hit plus
  // discarded player hits around frame ph_at.
  task automatic invuln_run(input int sc, input logic [1:0] lv, input int first_k,
                            input int ph_at, output int sc_out);
    int cur;
    cur = sc;
    for (int k = first_k; k <= 59; k++) begin
      if (k == ph_at) begin
        drive(0, 0, 1, 8'd13, 0, 8'd0, 1);
        cur = sc + 13;
      end
      commit(1, 0, 0, 8'd0, 0, 8'd0, (k == ph_at + 10),
             e(14'(cur), lv, 1'b0, (k < 59), (k < 59) && (((k / 8) % 2) == 1)));
    end
    sc_out = cur;
  endtask

  // Reaches 980 with one hit, then crosses 1000 inside the invulnerability window.
  task automatic crossing();
    drive(0, 0, 1, 8'd255, 1, 8'd255, 1);
    drive(0, 0, 1, 8'd255, 1, 8'd215, 0);
    frame(e(14'd980, 2'd2, 1'b0, 1'b1, 1'b0));
    drive(0, 0, 1, 8'd30, 0, 8'd0, 0);
    frame(e(14'd1010, BONUS_LV, 1'b0, 1'b1, 1'b0));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_score"}, int'(bus.score), 0);
    chk({tag, "_lives"}, int'(bus.lives), 3);
    chk({tag, "_game_over"}, int'(bus.game_over), 0);
    chk({tag, "_invuln"}, int'(bus.invuln), 0);
    chk({tag, "_blink"}, int'(bus.lives_blink), 0);
    chk({tag, "_state"}, int'(dbg_state), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sc;
    logic [1:0] lv;

    bus.frame_start = 0; bus.game_start = 0; bus.alien_hit = 0; bus.alien_pts = 0;
    bus.ufo_hit = 0; bus.ufo_pts = 0; bus.player_hit = 0;
    repeat (3) idle();
    chk_reset_state("reset");
    rst_n = 1'b1;

    // IDLE ignores hits and frames; game start and quiet frames keep zero
    drive(0, 0, 1, 8'd99, 1, 8'd50, 1);
    frame(e(14'd0, 2'd3, 1'b0, 1'b0, 1'b0));
    gstart(e(14'd0, 2'd3, 1'b0, 1'b0, 1'b0));
    repeat (3) frame(e(14'd0, 2'd3, 1'b0, 1'b0, 1'b0));

    // Simultaneous alien+UFO points, held until frame_start
    drive(0, 0, 1, 8'd10, 1, 8'd50, 0);
    idle();
    drive(0, 0, 1, 8'd20, 0, 8'd0, 0);
    idle();
    chk("score_before_commit", int'(bus.score), 0);
    commit(1, 0, 1, 8'd7, 0, 8'd0, 0, e(14'd80, 2'd3, 1'b0, 1'b0, 1'b0));
    frame(e(14'd87, 2'd3, 1'b0, 1'b0, 1'b0));

    // Player hit -> invulnerability with blinking, hits discarded, points kept
    drive(0, 0, 0, 8'd0, 0, 8'd0, 1);
    frame(e(14'd87, 2'd2, 1'b0, 1'b1, 1'b0));
    idle();
    chk("state_invuln", int'(dbg_state), 2);
    invuln_run(87, 2'd2, 1, 10, sc);
    idle();
    chk("state_play_after_invuln", int'(dbg_state), 1);

    // Hit on the frame_start cycle belongs to the next frame; last life -> game over
    commit(1, 0, 0, 8'd0, 0, 8'd0, 1, e(14'd100, 2'd2, 1'b0, 1'b0, 1'b0));
    frame(e(14'd100, 2'd1, 1'b0, 1'b1, 1'b0));
    invuln_run(100, 2'd1, 1, 30, sc);
    drive(0, 0, 0, 8'd0, 0, 8'd0, 1);
    drive(0, 0, 1, 8'd40, 0, 8'd0, 0);
    frame(e(14'd153, 2'd0, 1'b1, 1'b0, 1'b0));
    idle();
    chk("state_game_over", int'(dbg_state), 3);
    drive(0, 0, 1, 8'd50, 1, 8'd60, 1);
    frame(e(14'd153, 2'd0, 1'b1, 1'b0, 1'b0));
    commit(1, 0, 1, 8'd9, 0, 8'd0, 1, e(14'd153, 2'd0, 1'b1, 1'b0, 1'b0));
    gstart(e(14'd0, 2'd3, 1'b0, 1'b0, 1'b0));

    // Pending saturation at 1023, then score saturation at 9999
    repeat (3) drive(0, 0, 1, 8'd255, 1, 8'd255, 0);
    frame(e(14'd1023, 2'd3, 1'b0, 1'b0, 1'b0));
    for (int i = 1; i <= 8; i++) begin
      repeat (2) drive(0, 0, 1, 8'd255, 1, 8'd255, 0);
      frame(e(14'(1023 + 1020 * i), 2'd3, 1'b0, 1'b0, 1'b0));
    end
    drive(0, 0, 1, 8'd255, 1, 8'd255, 0);
    drive(0, 0, 1, 8'd255, 0, 8'd0, 0);
    drive(0, 0, 0, 8'd0, 1, 8'd42, 0);
    frame(e(14'd9990, 2'd3, 1'b0, 1'b0, 1'b0));
    drive(0, 0, 1, 8'd30, 0, 8'd0, 0);
    frame(e(14'd9999, 2'd3, 1'b0, 1'b0, 1'b0));
    drive(0, 0, 1, 8'd100, 0, 8'd0, 0);
    frame(e(14'd9999, 2'd3, 1'b0, 1'b0, 1'b0));
    gstart(e(14'd9999, 2'd3, 1'b0, 1'b0, 1'b0));

    // Reset mid-frame drops pending points and hits
    drive(0, 0, 1, 8'd50, 0, 8'd0, 1);
    idle();
    rst_n = 1'b0;
    repeat (2) idle();
    chk_reset_state("midreset");
    rst_n = 1'b1;
    gstart(e(14'd0, 2'd3, 1'b0, 1'b0, 1'b0));

    // 1000-point crossing with lives=2, play to game over, restart and cross again
    crossing();
    invuln_run(1010, BONUS_LV, 2, 100, sc);
    lv = BONUS_LV;
    while (lv > 2'd1) begin
      drive(0, 0, 0, 8'd0, 0, 8'd0, 1);
      lv = lv - 2'd1;
      frame(e(14'd1010, lv, 1'b0, 1'b1, 1'b0));
      invuln_run(1010, lv, 1, 100, sc);
    end
    drive(0, 0, 0, 8'd0, 0, 8'd0, 1);
    frame(e(14'd1010, 2'd0, 1'b1, 1'b0, 1'b0));
    gstart(e(14'd0, 2'd3, 1'b0, 1'b0, 1'b0));
    crossing();

    repeat (3) idle();
    chk("exp_q_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hud_ctrl.md
Name: hud_ctrl

Overview:
Frame-synchronous game-state controller that owns the score and lives values shown by the HUD renderer.
- Arbitrates concurrent scoring events from the alien and UFO collision units, plus player-hit events.
- Accumulates them during the frame and commits them only at frame start, so the displayed values never change mid-scan.
- Sequences play, invulnerability and game-over states.

Parameters:
START_LIVES, 3, lives loaded on game start (1..3)
SCORE_MAX, 9999, saturation ceiling of committed score
INVULN_FRAMES, 60, frames of hit immunity after losing a life
BLINK_FRAMES, 8, frames per half-period of lives_blink

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
frame_start  in  1  one-cycle pulse at start of vertical blank
game_start  in  1  one-cycle start request
alien_hit  in  1  alien destroyed this cycle
alien_pts  in  8  points for alien_hit
ufo_hit  in  1  UFO destroyed this cycle
ufo_pts  in  8  points for ufo_hit
player_hit  in  1  player ship struck this cycle
score  out  14  committed score, 0..SCORE_MAX
lives  out  2  committed lives, 0..3
game_over  out  1  high in GAME_OVER state
lives_blink  out  1  blink gate for lives icons
invuln  out  1  high in INVULN state

Behaviour:
Interface:
- Single clock clk.
- Reset rst_n is synchronous and active-low.

Reset (rst_n=0 at a clk edge):
- state=IDLE, score=0, lives=START_LIVES.
- game_over=0, lives_blink=0, invuln=0.
- pend_pts=0, hit_pend=0, frame counters=0.

FSM states: IDLE, PLAY, INVULN, GAME_OVER.
- IDLE / GAME_OVER + game_start -> PLAY.
  - Same edge: score=0, lives=START_LIVES, pend_pts=0, hit_pend=0.
- game_start in PLAY or INVULN is ignored.
- All hit inputs are ignored in IDLE and GAME_OVER. Score and lives stay frozen there.

Point accumulation (PLAY and INVULN):
- pend_pts is 10-bit and saturates at 1023.
- Each cycle: pend_pts += (alien_hit ? alien_pts : 0) + (ufo_hit ? ufo_pts : 0).
- Simultaneous alien_hit and ufo_hit: both values are added, none dropped.

Player hits:
- player_hit in PLAY sets sticky hit_pend.
- player_hit in INVULN is discarded.

Commit on a frame_start cycle (PLAY/INVULN):
- score <= min(score + pend_pts, SCORE_MAX), computed at 15-bit width before clamping.
- pend_pts <= hit inputs arriving in that same cycle. Those events belong to the next frame.
- If hit_pend: lives <= lives-1 and hit_pend cleared.
  - New lives == 0 -> GAME_OVER. Points pending in that frame are still committed.
  - New lives > 0 -> INVULN, inv_cnt=0.
- A player_hit in the same cycle as frame_start sets hit_pend for the next frame.
- Outputs update on the edge after the frame_start cycle, i.e. 1-cycle latency.

INVULN state:
- inv_cnt increments on each frame_start.
- Return to PLAY on the frame_start where inv_cnt reaches INVULN_FRAMES-1.
- invuln=1 throughout INVULN.
- lives_blink toggles every BLINK_FRAMES frame_starts and is forced 0 outside INVULN.

Boundary rules:
- lives never underflows.
- score never exceeds SCORE_MAX; at saturation, further points are discarded.
- frame_start in IDLE/GAME_OVER has no effect.
- Reset mid-frame discards all pending points and hits.

Optional Feature:
Macro: HUD_EXTRA_LIFE_EN
- Defined:
  - One bonus life is awarded on the commit where score first crosses from <1000 to >=1000.
  - Bonus applies only if lives<3 after any decrement in the same commit.
  - One-shot flag, cleared on game_start/reset.
  - A crossing into GAME_OVER (lives reaching 0 that commit) awards nothing.
- Not defined:
  - No bonus logic is present.
  - lives only decreases during a game.

Test Plan:
1. Reset then game_start -> score=0, lives=3, game_over=0. Three frame_starts with no hits -> score stays 0.
2. alien_hit pts=10 and ufo_hit pts=50 in the same cycle, plus alien_hit pts=20 later, then frame_start -> score=80 one cycle after frame_start, and not before.
3. score=9990, pend 30 -> score=9999. Further 100 pts next frame -> score stays 9999.
4. player_hit in PLAY then frame_start -> lives=2, invuln=1. lives_blink toggles every 8 frames. player_hit during INVULN -> lives unchanged. After 60 frame_starts -> invuln=0.
5. lives=1, player_hit plus 40 pts in the same frame, then frame_start -> lives=0, score+40, game_over=1. Later hits/frames leave values frozen; game_start -> score=0, lives=3.
6. Under HUD_EXTRA_LIFE_EN: lives=2, score 980 + pend 30 -> score=1010, lives=3. A second crossing after a restart awards again; without the macro, lives stays 2.
